ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Upstream feeder for the configuration-chain (ccff) of the I/O and logic tiles. Accepts configuration words
//  from the SoC side over a valid/ready handshake. Serialises them MSB-first onto ccff_head and gates the
//  programming clock so the chain advances only when a valid bit is present. Compresses the bits returned on
//  ccff_tail into a CRC-16 readback signature.
// PARAMETERS
//  DATA_WIDTH   32       width of a configuration word accepted on cfg_data
//  LEN_W        20       width of chain_len, the maximum chain length in bits
//  CRC_INIT     16'hFFFF reset/seed value of the tail signature
// PORTS
//  prog_clk      in   1           programming clock; the only clock
//  prog_reset_n  in   1           asynchronous, active-low reset
//  start         in   1           single-cycle pulse; begins a load (IDLE only)
//  abort         in   1           terminates a load in progress
//  chain_len     in   LEN_W       number of bits to shift; sampled on start
//  cfg_data      in   DATA_WIDTH  configuration word, MSB shifted first
//  cfg_valid     in   1           cfg_data valid
//  cfg_ready     out  1           loader can accept a word
//  ccff_head     out  1           serial bit into the chain
//  ccff_clk_en   out  1           clock-gate enable for the chain's prog_clk
//  ccff_tail     in   1           serial bit out of the chain
//  busy          out  1           load in progress
//  done          out  1           one-cycle pulse; chain_len bits shifted
//  aborted       out  1           one-cycle pulse; load aborted
//  tail_sig      out  16          CRC-16-CCITT (poly 0x1021) over the sampled ccff_tail bits
// BEHAVIOUR
//  - Reset values: cfg_ready, ccff_head, ccff_clk_en, busy, done and aborted = 0; tail_sig = CRC_INIT;
//    FSM state = IDLE; both word buffers empty.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE -> SHIFT on start with chain_len != 0: latch bit counter = chain_len, seed CRC to CRC_INIT.
//    IDLE -> DONE on start with chain_len == 0: no shifting; tail_sig = CRC_INIT.
//    SHIFT -> DONE on the cycle the last bit is shifted.
//    DONE -> IDLE after exactly one cycle; done = 1 while in DONE.
//    SHIFT -> IDLE on abort: aborted pulses the next cycle; buffers are flushed; tail_sig keeps its partial value.
//  - start is ignored outside IDLE. abort is ignored in IDLE and DONE. abort and start in the same cycle in
//    IDLE: start wins.
//  - Buffering: a shift register (SR) plus a holding register (HR), each holding one word.
//    cfg_ready = (state == SHIFT) && HR empty; cfg_ready is 0 in IDLE and DONE.
//    A word moves HR -> SR in the same cycle SR's last bit is consumed, so a continuous stream sustains
//    1 bit/cycle.
//  - Shift cycle: when SR holds a bit and the counter is nonzero, the next cycle has ccff_head = SR MSB,
//    ccff_clk_en = 1, and the counter decrements. ccff_head and ccff_clk_en are registered together.
//  - Stall: SR empty and HR empty -> ccff_clk_en = 0 and ccff_head holds its value; the chain does not advance.
//  - Tail: ccff_tail is sampled on every cycle where ccff_clk_en = 1 (the value before the shift) and fed
//    into the CRC, MSB-first serial update.
//  - End of load: when the counter reaches 0, any unused SR/HR bits are discarded and both buffers are
//    cleared on the entry to DONE.
//  - Counter width: LEN_W. The counter never wraps; decrement is blocked at 0.
//  - busy = 1 in SHIFT and DONE.
//  - Reset asserted mid-load: immediately return to the reset values; the chain holds its partial contents.
// STRUCTURE
//  - Package ccff_loader_pkg: state enum (IDLE/SHIFT/DONE), CRC_POLY = 16'h1021, default CRC_INIT.
//  - One sub-module ccff_crc16_serial (clk, rst_n, init, en, din, crc) holds the signature register.
//  - The top level contains the FSM, the SR/HR datapath and the bit counter.
// TESTING
//  1. Reset, then DATA_WIDTH=32, chain_len=8, one word 0xA5000000 held valid -> ccff_head = 1,0,1,0,0,1,0,1
//     on 8 consecutive clk_en cycles; done pulses once; the low 24 bits are discarded; cfg_ready = 0 after.
//  2. chain_len=96, three words streamed back-to-back -> 96 contiguous ccff_clk_en cycles with no gap;
//     done pulses 1 cycle after the last bit.
//  3. chain_len=64, second word delayed 5 cycles -> ccff_clk_en low for exactly those stall cycles;
//     total clk_en count = 64.
//  4. ccff_tail tied to ccff_head through a 4-bit delay model, load 0xFFFFFFFF, chain_len=32 ->
//     tail_sig equals the reference-model CRC of 0000 followed by 28 ones.
//  5. abort after 10 bits of a 40-bit load -> aborted pulses once; done never pulses; busy=0;
//     a following start reloads cleanly.
//  6. start with chain_len=0 -> done pulses on the next cycle, no clk_en, tail_sig=0xFFFF;
//     prog_reset_n asserted mid-SHIFT -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader and its
// readback signature register.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [15:0] CRC_POLY         = 16'h1021;
   localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

   // One MSB-first serial step of CRC-16-CCITT.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Valid/ready word channel from the SoC side into the chain loader.
interface ccff_chain_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] cfg_data;
   logic                  cfg_valid;
   logic                  cfg_ready;

   modport master (output cfg_data, output cfg_valid, input  cfg_ready);
   modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// Serial CRC-16-CCITT signature register over the bits returned by the chain.
module ccff_crc16_serial
   import ccff_loader_pkg::*;
#(
   parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         crc <= CRC_INIT;
      else if (init)
         crc <= CRC_INIT;
      else if (en)
         crc <= crc16_step(crc, din);
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words MSB-first into the ccff chain with a gated
// chain clock, and signs the returned tail bits with a CRC-16.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          LEN_W      = 20,
   parameter logic [15:0] CRC_INIT   = CRC_INIT_DEFAULT
) (
   input  logic             prog_clk,
   input  logic             prog_reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] chain_len,
   ccff_chain_loader_if.slave cfg,
   output logic             ccff_head,
   output logic             ccff_clk_en,
   input  logic             ccff_tail,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [15:0]      tail_sig
);

   localparam int BW = $clog2(DATA_WIDTH + 1);

   state_t                state, state_nxt;
   logic [LEN_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] sr, hr;
   logic [BW-1:0]         sr_bits;
   logic                  hr_full;
   logic                  aborted_q;

   logic go, do_abort, finish;
   logic shift, accept, load_sr;

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) state <= IDLE;
      else               state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      do_abort  = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            go        = 1'b1;
            state_nxt = (chain_len == '0) ? DONE : SHIFT;
         end
         SHIFT: if (abort) begin
            do_abort  = 1'b1;
            state_nxt = IDLE;
         end else if (cnt == '0) begin
            finish    = 1'b1;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign cfg.cfg_ready = (state == SHIFT) && !hr_full;
   assign accept        = cfg.cfg_valid && cfg.cfg_ready;
   assign shift         = (state == SHIFT) && !abort && (sr_bits != '0) && (cnt != '0);
   // Refill on an empty SR or on the cycle its last bit leaves, so a stream never gaps.
   assign load_sr       = hr_full && ((sr_bits == '0) || (shift && sr_bits == BW'(1)));

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         cnt         <= '0;
         sr          <= '0;
         hr          <= '0;
         sr_bits     <= '0;
         hr_full     <= 1'b0;
         ccff_head   <= 1'b0;
         ccff_clk_en <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         aborted_q   <= do_abort;
         ccff_clk_en <= shift;
         if (shift) begin
            ccff_head <= sr[DATA_WIDTH-1];
            cnt       <= cnt - LEN_W'(1);
         end
         if (go)
            cnt <= chain_len;
         if (go || do_abort || finish) begin
            sr_bits <= '0;
            hr_full <= 1'b0;
         end else begin
            if (load_sr) begin
               sr      <= hr;
               sr_bits <= BW'(DATA_WIDTH);
            end else if (shift) begin
               sr      <= sr << 1;
               sr_bits <= sr_bits - BW'(1);
            end
            if (accept) begin
               hr      <= cfg.cfg_data;
               hr_full <= 1'b1;
            end else if (load_sr) begin
               hr_full <= 1'b0;
            end
         end
      end
   end

   ccff_crc16_serial #(
      .CRC_INIT (CRC_INIT)
   ) u_crc (
      .clk   (prog_clk),
      .rst_n (prog_reset_n),
      .init  (go),
      .en    (ccff_clk_en),
      .din   (ccff_tail),
      .crc   (tail_sig)
   );

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign aborted = aborted_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: word serialisation, streaming, stalls,
// tail signature, abort and reset behaviour.
module tb_ccff_chain_loader;
   import ccff_loader_pkg::*;

   localparam int DW = 32;
   localparam int LW = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort;
   logic [LW-1:0] chain_len;
   logic          ccff_head, ccff_clk_en, ccff_tail;
   logic          busy, done, aborted;
   logic [15:0]   tail_sig;

   ccff_chain_loader_if #(.DATA_WIDTH(DW)) cfg_if ();

   ccff_chain_loader #(.DATA_WIDTH(DW), .LEN_W(LW), .CRC_INIT(16'hFFFF)) dut (
      .prog_clk     (clk),
      .prog_reset_n (rst_n),
      .start        (start),
      .abort        (abort),
      .chain_len    (chain_len),
      .cfg          (cfg_if),
      .ccff_head    (ccff_head),
      .ccff_clk_en  (ccff_clk_en),
      .ccff_tail    (ccff_tail),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .tail_sig     (tail_sig)
   );

   always #5 clk = ~clk;

   // Four-stage chain model clocked by the gated programming clock.
   logic [3:0] chain4 = 4'h0;
   always @(posedge clk) if (ccff_clk_en) chain4 <= {chain4[2:0], ccff_head};
   assign ccff_tail = chain4[3];

   int tests = 0;
   int fails = 0;

   int cyc = 0, en_cnt = 0, first_en = 0, last_en = 0;
   int done_cnt = 0, done_cyc = 0, aborted_cnt = 0;
   logic [127:0] head_log = '0;

   always @(negedge clk) begin
      cyc++;
      if (ccff_clk_en) begin
         if (en_cnt == 0) first_en = cyc;
         last_en  = cyc;
         en_cnt++;
         head_log = {head_log[126:0], ccff_head};
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (aborted) aborted_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      en_cnt = 0; done_cnt = 0; aborted_cnt = 0; head_log = '0;
   endtask

   task automatic begin_load(input logic [LW-1:0] len);
      clear_mon();
      chain_len = len;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic send_word(input string tag, input logic [DW-1:0] w);
      int n = 0;
      cfg_if.cfg_data  = w;
      cfg_if.cfg_valid = 1'b1;
      while (!cfg_if.cfg_ready && n < 200) begin
         tick();
         n++;
      end
      check(tag, cfg_if.cfg_ready, 1'b1);
      tick();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic wait_en(input string tag, input int target);
      int n = 0;
      while (en_cnt < target && n < 300) begin
         tick();
         n++;
      end
      check(tag, en_cnt >= target, 1'b1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 300) begin
         tick();
         n++;
      end
      check(tag, done_cnt != 0, 1'b1);
      tick();
      tick();
   endtask

   function automatic logic [15:0] crc_ref(input logic [63:0] bits, input int n);
      logic [15:0] c = 16'hFFFF;
      for (int i = n - 1; i >= 0; i--) begin
         if (c[15] ^ bits[i]) c = (c << 1) ^ 16'h1021;
         else                 c = c << 1;
      end
      return c;
   endfunction

   initial begin
      rst_n            = 1'b0;
      start            = 1'b0;
      abort            = 1'b0;
      chain_len        = '0;
      cfg_if.cfg_data  = '0;
      cfg_if.cfg_valid = 1'b0;
      tick();
      tick();
      check("rst_ready",   cfg_if.cfg_ready, 1'b0);
      check("rst_head",    ccff_head,        1'b0);
      check("rst_clk_en",  ccff_clk_en,      1'b0);
      check("rst_busy",    busy,             1'b0);
      check("rst_done",    done,             1'b0);
      check("rst_aborted", aborted,          1'b0);
      check("rst_sig",     tail_sig,         16'hFFFF);
      rst_n = 1'b1;
      tick();

      // 1: single word, only the top 8 bits leave the loader.
      begin_load(20'd8);
      send_word("t1_hs", 32'hA500_0000);
      wait_done("t1_done_seen");
      check("t1_en_cnt",   en_cnt,                 32'd8);
      check("t1_head",     head_log[7:0],          8'hA5);
      check("t1_no_gap",   last_en - first_en + 1, 32'd8);
      check("t1_done_one", done_cnt,               32'd1);
      check("t1_ready",    cfg_if.cfg_ready,       1'b0);
      check("t1_busy",     busy,                   1'b0);

      // 2: three words back-to-back give one contiguous 96-bit burst.
      begin_load(20'd96);
      send_word("t2_hs0", 32'h1234_5678);
      send_word("t2_hs1", 32'h9ABC_DEF0);
      send_word("t2_hs2", 32'h0F0F_0F0F);
      wait_done("t2_done_seen");
      check("t2_en_cnt",   en_cnt,                 32'd96);
      check("t2_no_gap",   last_en - first_en + 1, 32'd96);
      check("t2_head",     head_log[95:0],         96'h12345678_9ABCDEF0_0F0F0F0F);
      check("t2_done_lat", done_cyc,               last_en + 1);
      check("t2_done_one", done_cnt,               32'd1);

      // 3: word 2 presented two cycles after the last word-1 bit shows on the
      // head; with valid->HR->SR->head taking three cycles the chain idles 5.
      begin_load(20'd64);
      send_word("t3_hs0", 32'hDEAD_BEEF);
      wait_en("t3_wait32", 32);
      tick();
      tick();
      send_word("t3_hs1", 32'hCAFE_F00D);
      wait_done("t3_done_seen");
      check("t3_en_cnt", en_cnt,                          32'd64);
      check("t3_stall",  last_en - first_en + 1 - en_cnt, 32'd5);
      check("t3_head",   head_log[63:0],                  64'hDEADBEEF_CAFEF00D);

      // 4: tail returns the head through four stages that start empty.
      chain4 = 4'h0;
      begin_load(20'd32);
      send_word("t4_hs", 32'hFFFF_FFFF);
      wait_done("t4_done_seen");
      check("t4_en_cnt", en_cnt,   32'd32);
      check("t4_sig",    tail_sig, crc_ref(64'h0FFF_FFFF, 32));

      // abort is ignored while idle
      clear_mon();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      check("idle_abort_busy",    busy,        1'b0);
      check("idle_abort_aborted", aborted_cnt, 32'd0);

      // 5: abort once 10 bits have been seen; the bit already on the head
      // in that cycle still clocks, so 11 bits leave in total.
      begin_load(20'd40);
      send_word("t5_hs0", 32'h1357_9BDF);
      send_word("t5_hs1", 32'h2468_ACE0);
      wait_en("t5_wait10", 10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      tick();
      check("t5_aborted_one", aborted_cnt,      32'd1);
      check("t5_no_done",     done_cnt,         32'd0);
      check("t5_busy",        busy,             1'b0);
      check("t5_clk_en",      ccff_clk_en,      1'b0);
      check("t5_ready",       cfg_if.cfg_ready, 1'b0);
      check("t5_en_cnt",      en_cnt,           32'd11);

      // reload; start and abort together in idle, start wins
      clear_mon();
      chain_len = 20'd8;
      start     = 1'b1;
      abort     = 1'b1;
      tick();
      start     = 1'b0;
      abort     = 1'b0;
      check("t5_reload_busy", busy, 1'b1);
      send_word("t5_hs2", 32'h3C00_0000);
      wait_done("t5_reload_done_seen");
      check("t5_reload_head", head_log[7:0], 8'h3C);
      check("t5_reload_en",   en_cnt,        32'd8);
      check("t5_reload_done", done_cnt,      32'd1);
      check("t5_reload_abrt", aborted_cnt,   32'd0);

      // 6: zero-length load goes straight to DONE.
      begin_load(20'd0);
      check("t6_done",    done,        1'b1);
      check("t6_busy",    busy,        1'b1);
      check("t6_clk_en",  ccff_clk_en, 1'b0);
      check("t6_sig",     tail_sig,    16'hFFFF);
      tick();
      check("t6_done_lo", done,        1'b0);
      check("t6_idle",    busy,        1'b0);
      check("t6_en_cnt",  en_cnt,      32'd0);

      // reset asserted mid-SHIFT
      begin_load(20'd64);
      send_word("t6_hs", 32'hFFFF_FFFF);
      wait_en("t6_wait3", 3);
      rst_n = 1'b0;
      #1;
      check("t6r_head",    ccff_head,        1'b0);
      check("t6r_clk_en",  ccff_clk_en,      1'b0);
      check("t6r_busy",    busy,             1'b0);
      check("t6r_ready",   cfg_if.cfg_ready, 1'b0);
      check("t6r_done",    done,             1'b0);
      check("t6r_aborted", aborted,          1'b0);
      check("t6r_sig",     tail_sig,         16'hFFFF);
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
